mem_access_unit: RTL

Data-side memory access sequencer sitting directly downstream of the MMU in the MEM stage. Accepts one load/store request at a time and drives the MMU data port with the held virtual address. Classifies the MMU result into a MIPS exception or a bus transaction. Runs the bus valid/ready handshake and returns lane-extracted, sign/zero-extended load data.

---
 rtl/mem_access_unit.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer between MMU and data bus
// ADDR_ALIGN_CHECK_EN: raise AdEL/AdES on misaligned half/word accesses instead of masking low bits
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mmu_vaddr,
  input  logic [31:0] mmu_paddr,
  input  logic        mmu_miss,
  input  logic        mmu_valid,
  input  logic        mmu_dirty,
  input  logic        mmu_illegal,
  input  logic [2:0]  mmu_cache,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic        resp_refill,
  output logic [31:0] resp_badvaddr
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] baddr_q, baddr_d;
  logic        bwe_q, bwe_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic        unc_q, unc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [4:0]  code_q, code_d;
  logic        refill_q, refill_d;
  logic [31:0] badv_q, badv_d;

  logic        is_byte, is_half, mapped, misalign;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, shifted, ld_c;
  logic        exc_c, refill_c, uncached_c;
  logic [4:0]  code_c;

  assign is_byte = (size_q == 2'd0);
  assign is_half = (size_q == 2'd1);
  assign mapped  = (vaddr_q[31:30] != 2'b10);

  // Lane offset with the low bits that cannot address a half/word dropped.
  assign off = is_byte ? vaddr_q[1:0] : (is_half ? {vaddr_q[1], 1'b0} : 2'b00);

`ifdef ADDR_ALIGN_CHECK_EN
  assign misalign = (is_half & vaddr_q[0]) | (~is_byte & ~is_half & (vaddr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign be_c = is_byte ? (4'b0001 << off) : (is_half ? (4'b0011 << off) : 4'b1111);
  assign wdata_c = is_byte ? {4{wdata_q[7:0]}} : (is_half ? {2{wdata_q[15:0]}} : wdata_q);
  assign uncached_c = (vaddr_q[31:29] == 3'b101) | (mapped & (mmu_cache == 3'd2));
  assign shifted = bus_rdata >> {off, 3'b000};

  always_comb begin
    ld_c = shifted;
    if (is_byte)      ld_c = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
    else if (is_half) ld_c = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
  end

  always_comb begin
    exc_c    = 1'b0;
    code_c   = 5'd0;
    refill_c = 1'b0;
    if (misalign | mmu_illegal) begin
      exc_c  = 1'b1;
      code_c = we_q ? 5'd5 : 5'd4;
    end else if (mapped & mmu_miss) begin
      exc_c    = 1'b1;
      code_c   = we_q ? 5'd3 : 5'd2;
      refill_c = 1'b1;
    end else if (!mmu_valid) begin
      exc_c  = 1'b1;
      code_c = we_q ? 5'd3 : 5'd2;
    end else if (we_q & !mmu_dirty) begin
      exc_c  = 1'b1;
      code_c = 5'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    vaddr_d  = vaddr_q;
    we_d     = we_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    wdata_d  = wdata_q;
    baddr_d  = baddr_q;
    bwe_d    = bwe_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    unc_d    = unc_q;
    rdata_d  = rdata_q;
    exc_d    = exc_q;
    code_d   = code_q;
    refill_d = refill_q;
    badv_d   = badv_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          vaddr_d = req_vaddr;
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (exc_c) begin
          exc_d    = 1'b1;
          code_d   = code_c;
          refill_d = refill_c;
          badv_d   = vaddr_q;
          rdata_d  = 32'd0;
          state_d  = S_RESP;
        end else begin
          baddr_d  = mmu_paddr & 32'hFFFF_FFFC;
          bwe_d    = we_q;
          be_d     = be_c;
          bwdata_d = wdata_c;
          unc_d    = uncached_c;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus_ready) begin
          if (we_q) begin
            exc_d    = 1'b0;
            code_d   = 5'd0;
            refill_d = 1'b0;
            badv_d   = 32'd0;
            rdata_d  = 32'd0;
            state_d  = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          exc_d    = 1'b0;
          code_d   = 5'd0;
          refill_d = 1'b0;
          badv_d   = 32'd0;
          rdata_d  = ld_c;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      vaddr_q  <= 32'd0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      sgn_q    <= 1'b0;
      wdata_q  <= 32'd0;
      baddr_q  <= 32'd0;
      bwe_q    <= 1'b0;
      be_q     <= 4'd0;
      bwdata_q <= 32'd0;
      unc_q    <= 1'b0;
      rdata_q  <= 32'd0;
      exc_q    <= 1'b0;
      code_q   <= 5'd0;
      refill_q <= 1'b0;
      badv_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      vaddr_q  <= vaddr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      wdata_q  <= wdata_d;
      baddr_q  <= baddr_d;
      bwe_q    <= bwe_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      unc_q    <= unc_d;
      rdata_q  <= rdata_d;
      exc_q    <= exc_d;
      code_q   <= code_d;
      refill_q <= refill_d;
      badv_q   <= badv_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign bus_valid     = (state_q == S_ISSUE);
  assign resp_valid    = (state_q == S_RESP);
  assign mmu_vaddr     = vaddr_q;
  assign bus_addr      = baddr_q;
  assign bus_we        = bwe_q;
  assign bus_be        = be_q;
  assign bus_wdata     = bwdata_q;
  assign bus_uncached  = unc_q;
  assign resp_rdata    = rdata_q;
  assign resp_exc      = exc_q;
  assign resp_exc_code = code_q;
  assign resp_refill   = refill_q;
  assign resp_badvaddr = badv_q;

endmodule
